uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered, runtime-configurable UART transmitter: FIFO-fed successor to the single-byte TX.
//  Accepts words on a valid/ready stream into an internal FIFO.
//  Serialises frames LSB-first with optional parity and 1/2 stop bits at a runtime baud divisor.
//  Frames go back-to-back with no idle gap. Sits between SoC/CPU logic and the board TX pin.
// PARAMETERS
//  DATA_BITS   8     payload bits per frame, legal 5..9
//  STOP_BITS   1     stop bits, legal 1 or 2
//  PARITY      0     0=none, 1=odd, 2=even
//  FIFO_DEPTH  16    TX FIFO entries, power of two >= 2
//  DIV_W       16    width of baud divisor input
// PORTS
//  clk           in   1          clock
//  n_rst         in   1          reset, asynchronous, active-low
//  i_valid       in   1          write request
//  i_data        in   DATA_BITS  word to send
//  o_ready       out  1          FIFO not full; transfer when i_valid & o_ready at rising edge
//  i_baud_div    in   DIV_W      clocks per bit; sampled at each frame start
//  o_tx          out  1          serial line, registered, idle high
//  o_busy        out  1          frame in progress or FIFO non-empty
//  o_level       out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  i_cts_n       in   1          clear-to-send, active-low (UART_TX_CTS_EN only)
// BEHAVIOUR
//  Reset: o_tx=1, o_busy=0, o_level=0, o_ready=1; FIFO flushed, FSM->IDLE. Applies mid-frame; no partial bits.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE->START: when FIFO non-empty. Pops head into shift reg and latches i_baud_div (div<2 uses 2).
//  - START->DATA->(PARITY)->STOP: transitions at bit-end.
//  - STOP end: ->START if FIFO non-empty, else ->IDLE.
//  Bit timing: every bit lasts exactly div clocks; frame = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*div clocks.
//  Latency: word accepted at edge E into empty FIFO with FSM in IDLE -> o_tx low from edge E+1.
//  DATA: o_tx = shift[0], logical right shift at bit-end; bit counter 0..DATA_BITS-1.
//  Parity: XOR of the payload, registered at pop. Odd => bit=~xor; even => bit=xor.
//  FIFO: write and pop in the same cycle while full is legal; level unchanged, o_ready stays 0 that cycle.
//  o_ready is combinational from registered full flag. i_valid with o_ready=0 is ignored (no overwrite).
//  i_data is only sampled on a handshake. Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
//  i_baud_div changes mid-frame take effect at the next frame only.
// CONFIGURATION
//  UART_TX_CTS_EN defined:
//  - i_cts_n is passed through a 2-flop synchroniser.
//  - IDLE->START and STOP->START are gated by synchronised cts_n==0. A frame in progress always completes.
//  UART_TX_CTS_EN undefined: i_cts_n port absent; frames start whenever the FIFO is non-empty.
// STRUCTURE
//  uart_pkg: parity enum (PAR_NONE/PAR_ODD/PAR_EVEN), tx FSM state enum, frame-length function.
//  Sub-module sync_fifo (DATA_BITS wide, FIFO_DEPTH deep, push/pop/full/empty/level).
//  Top holds FSM, baud counter, bit counter, shift reg, CTS sync.
// TESTING
//  1. 8N1, div=4, write 0xA5.
//     -> o_tx: 4 clk low, then 1,0,1,0,0,1,0,1 (4 clk each), 4 clk high; o_busy drops after stop.
//  2. Depth 16, div=2: burst 20 writes.
//     -> o_ready low after 16 entries (minus pops); all 20 frames back-to-back, no idle gap, order kept.
//  3. PARITY=2 with 0x03 -> parity bit 0; PARITY=1 with 0x03 -> parity bit 1.
//     STOP_BITS=2 -> 2*div high clocks before the next start.
//  4. Assert n_rst mid-DATA of a frame with 3 words queued.
//     -> o_tx=1 immediately, o_level=0, o_busy=0; no output after release until a new write.
//  5. Change i_baud_div 4->8 mid-frame.
//     -> current frame stays at 4 clk/bit; next frame uses 8.
//  6. UART_TX_CTS_EN: cts_n=1 with 2 words queued -> o_tx stays 1.
//     Drop cts_n -> start 3 clk later (sync + FSM). Raise cts_n mid-frame -> frame completes, next held.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   parity_e      : parity mode encoding (none / odd / even)
//   tx_state_e    : transmitter FSM states
//   frame_bits()  : number of bit periods in one serial frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int stop_bits,
                                    input int parity);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is always visible on rdata, so
// a pop consumes the word presented in the same cycle.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset (flushes the FIFO)
//   push/wdata : write request and data
//   pop        : remove head entry (ignored when empty)
//   rdata      : head entry
//   full/empty : registered status flags
//   level      : occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // Power-of-two depth: pointers wrap naturally; level tells full from empty.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
      full  <= (level_next == LVL_W'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// FIFO-fed UART transmitter. Words arrive on a valid/ready stream, are queued
// in a sync_fifo and sent LSB-first as start / data / [parity] / stop frames.
// Frames are emitted back-to-back while the FIFO holds data.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   i_valid     : write request; i_data accepted when i_valid & o_ready
//   i_data      : word to send (DATA_BITS)
//   o_ready     : FIFO not full
//   i_baud_div  : clocks per bit, latched at each frame start (values <2 use 2)
//   o_tx        : registered serial line, idle high
//   o_busy      : frame in progress or FIFO non-empty
//   o_level     : FIFO occupancy
//   i_cts_n     : clear-to-send, active-low (only with UART_TX_CTS_EN)
// Build option: define UART_TX_CTS_EN to add i_cts_n flow control; frame starts
// are then held while the synchronised cts_n is high.
// -----------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_valid,
  input  logic [DATA_BITS-1:0]        i_data,
  output logic                        o_ready,
  input  logic [DIV_W-1:0]            i_baud_div,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
`ifdef UART_TX_CTS_EN
  ,
  input  logic                        i_cts_n
`endif
);

  localparam parity_e PAR_MODE   = parity_e'(PARITY[1:0]);
  localparam bit      HAS_PAR    = (PAR_MODE != PAR_NONE);
  localparam int      FRAME_BITS = frame_bits(DATA_BITS, STOP_BITS, PARITY);
  localparam int      BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e              state;
  logic [DIV_W-1:0]       baud_cnt;
  logic [DIV_W-1:0]       div_lat;
  logic [DIV_W-1:0]       div_eff;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;
  logic                   tx;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   bit_end;
  logic                   cts_ok;
  logic                   start_ok;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  assign o_ready   = !fifo_full;
  assign fifo_push = i_valid && o_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .wdata (i_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  // ---------------------------------------------------------------------------
  // Clear-to-send gating
  // ---------------------------------------------------------------------------
`ifdef UART_TX_CTS_EN
  logic cts_s1;
  logic cts_s2;

  // Reset to "not clear" so nothing starts until a real low has been seen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= i_cts_n;
      cts_s2 <= cts_s1;
    end
  end

  assign cts_ok = !cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Frame sequencing
  // ---------------------------------------------------------------------------
  assign div_eff  = (i_baud_div < DIV_W'(2)) ? DIV_W'(2) : i_baud_div;
  assign bit_end  = (baud_cnt == div_lat - DIV_W'(1));
  assign start_ok = !fifo_empty && cts_ok;

  // A frame starts from IDLE, or directly at the end of the last stop bit so
  // consecutive frames have no idle gap. Only starts are gated by CTS.
  assign fifo_pop = start_ok &&
                    ((state == ST_IDLE) ||
                     ((state == ST_STOP) && bit_end && (bit_cnt == LAST_STOP)));

  assign o_tx   = tx;
  assign o_busy = (state != ST_IDLE) || !fifo_empty;

  // Baud counter: runs 0..div_lat-1 within every bit, parked at 0 in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      baud_cnt <= '0;
    end else if ((state == ST_IDLE) || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + DIV_W'(1);
    end
  end

  // Frame datapath: word, parity and divisor are captured together at pop so
  // later i_baud_div changes only affect the next frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift   <= '0;
      par_bit <= 1'b0;
      div_lat <= DIV_W'(2);
    end else if (fifo_pop) begin
      shift   <= fifo_rdata;
      par_bit <= (PAR_MODE == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
      div_lat <= div_eff;
    end else if ((state == ST_DATA) && bit_end) begin
      shift   <= shift >> 1;
    end
  end

  // FSM with registered line output: tx is loaded with the value of the bit
  // being entered, so it changes on the same edge as the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (fifo_pop) begin
            state <= ST_START;
            tx    <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              // shift[1] becomes shift[0] on this same edge.
              tx      <= shift[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (fifo_pop) begin
                state <= ST_START;
                tx    <= 1'b0;
              end else begin
                state <= ST_IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Drives three transmitter configurations from one shared stimulus stream and
// compares every output, every cycle, against a frame-level reference model:
//   d0 : 8 data, 1 stop, no parity,   16-deep FIFO
//   d1 : 8 data, 2 stop, even parity,  4-deep FIFO
//   d2 : 9 data, 1 stop, odd parity,   2-deep FIFO
// The model keeps a word queue per instance and, for the active frame, its
// start cycle and divisor; the expected line level is the frame bit indexed
// by (cycle - start) / divisor.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int N = 3;

  logic        clk   = 1'b0;
  logic        n_rst = 1'b0;
  logic        valid = 1'b0;
  logic [8:0]  data  = '0;
  logic [15:0] div   = 16'd4;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
  logic        c_prev1 = 1'b1;
  logic        c_prev2 = 1'b1;
`endif

  logic [N-1:0] rdy;
  logic [N-1:0] tx;
  logic [N-1:0] busy;
  logic [4:0]   lvl0;
  logic [2:0]   lvl1;
  logic [1:0]   lvl2;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut0 (
    .clk(clk), .n_rst(n_rst), .i_valid(valid), .i_data(data[7:0]),
    .o_ready(rdy[0]), .i_baud_div(div), .o_tx(tx[0]), .o_busy(busy[0]),
    .o_level(lvl0)
`ifdef UART_TX_CTS_EN
    , .i_cts_n(cts_n)
`endif
  );

  uart_tx_buffered #(
    .DATA_BITS(8), .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4), .DIV_W(16)
  ) dut1 (
    .clk(clk), .n_rst(n_rst), .i_valid(valid), .i_data(data[7:0]),
    .o_ready(rdy[1]), .i_baud_div(div), .o_tx(tx[1]), .o_busy(busy[1]),
    .o_level(lvl1)
`ifdef UART_TX_CTS_EN
    , .i_cts_n(cts_n)
`endif
  );

  uart_tx_buffered #(
    .DATA_BITS(9), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(2), .DIV_W(16)
  ) dut2 (
    .clk(clk), .n_rst(n_rst), .i_valid(valid), .i_data(data),
    .o_ready(rdy[2]), .i_baud_div(div), .o_tx(tx[2]), .o_busy(busy[2]),
    .o_level(lvl2)
`ifdef UART_TX_CTS_EN
    , .i_cts_n(cts_n)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int cfg_d[N]     = '{8, 8, 9};
  int cfg_s[N]     = '{1, 2, 1};
  int cfg_p[N]     = '{0, 2, 1};
  int cfg_depth[N] = '{16, 4, 2};

  logic [8:0] m_buf[N][16];
  int         m_head[N];
  int         m_cnt[N];
  int         m_acc[N];
  bit         m_act[N];
  int         m_start[N];
  int         m_div[N];
  logic [8:0] m_word[N];
  int         cyc = 0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return 1 + cfg_d[i] + ((cfg_p[i] != 0) ? 1 : 0) + cfg_s[i];
  endfunction

  // Level of bit b of the active frame: start, payload LSB-first, parity, stop.
  function automatic logic exp_bit(input int i, input int b);
    logic x;
    if (b == 0) return 1'b0;
    if (b <= cfg_d[i]) return m_word[i][b-1];
    if ((cfg_p[i] != 0) && (b == cfg_d[i] + 1)) begin
      x = ^m_word[i];
      return (cfg_p[i] == 1) ? ~x : x;
    end
    return 1'b1;
  endfunction

  task automatic model_reset(input int i);
    m_head[i] = 0;
    m_cnt[i]  = 0;
    m_act[i]  = 1'b0;
  endtask

  // One clock edge: a new frame may start when the line is free (idle or the
  // previous frame just ended) and a word was already queued before the edge;
  // a word is accepted when the queue was not full before the edge.
  task automatic model_step(input int i, input bit gate);
    bit         end_now;
    bit         accept;
    logic [8:0] w;
    end_now = m_act[i] && ((cyc - m_start[i]) == frame_len(i) * m_div[i]);
    accept  = valid && (m_cnt[i] < cfg_depth[i]);
    if (!m_act[i] || end_now) begin
      if ((m_cnt[i] > 0) && gate) begin
        m_word[i]  = m_buf[i][m_head[i]];
        m_head[i]  = (m_head[i] + 1) % 16;
        m_cnt[i]   = m_cnt[i] - 1;
        m_start[i] = cyc;
        m_div[i]   = (div < 16'd2) ? 2 : int'(div);
        m_act[i]   = 1'b1;
      end else begin
        m_act[i]   = 1'b0;
      end
    end
    if (accept) begin
      w = data & 9'((1 << cfg_d[i]) - 1);
      m_buf[i][(m_head[i] + m_cnt[i]) % 16] = w;
      m_cnt[i] = m_cnt[i] + 1;
      m_acc[i] = m_acc[i] + 1;
    end
  endtask

  function automatic int dut_level(input int i);
    if (i == 0) return int'(lvl0);
    if (i == 1) return int'(lvl1);
    return int'(lvl2);
  endfunction

  task automatic compare_outputs(input int i);
    logic ex_tx;
    ex_tx = m_act[i] ? exp_bit(i, (cyc - m_start[i]) / m_div[i]) : 1'b1;
    check($sformatf("d%0d tx @%0d", i, cyc), tx[i], ex_tx);
    check($sformatf("d%0d ready @%0d", i, cyc), rdy[i], m_cnt[i] < cfg_depth[i]);
    check($sformatf("d%0d level @%0d", i, cyc), dut_level(i), m_cnt[i]);
    check($sformatf("d%0d busy @%0d", i, cyc), busy[i], m_act[i] || (m_cnt[i] > 0));
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then compare outputs 1 time unit later.
  task automatic tick();
    bit gate;
    @(posedge clk);
    cyc++;
    gate = 1'b1;
`ifdef UART_TX_CTS_EN
    gate = (c_prev2 == 1'b0);
    if (!n_rst) begin
      c_prev1 = 1'b1;
      c_prev2 = 1'b1;
    end else begin
      c_prev2 = c_prev1;
      c_prev1 = cts_n;
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (!n_rst) model_reset(i);
      else        model_step(i, gate);
    end
    #1;
    for (int i = 0; i < N; i++) compare_outputs(i);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (m_act[i] || (m_cnt[i] > 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    valid = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    while (!all_idle() && (n < budget)) begin
      tick();
      n++;
    end
    check({tag, " drain in budget"}, all_idle(), 1'b1);
    repeat (3) tick();
  endtask

  task automatic send(input logic [8:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
  endtask

  int divs[7] = '{0, 1, 2, 3, 4, 5, 7};

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      valid = ($urandom_range(0, 99) < 35);
      data  = 9'($urandom);
      if ($urandom_range(0, 59) == 0) div = 16'(divs[$urandom_range(0, 6)]);
`ifdef UART_TX_CTS_EN
      if ($urandom_range(0, 39) == 0) cts_n = ($urandom_range(0, 9) < 3);
`endif
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      model_reset(i);
      m_acc[i] = 0;
    end

    // Reset state.
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (2) tick();

    // Single 8N1 frame of 0xA5 at div 4, then 0x03 for the parity bits.
    div = 16'd4;
    send(9'h0A5);
    drain("a5", 400);
    send(9'h003);
    drain("p03", 400);

    // Divisors below 2 run at 2 clocks per bit.
    div = 16'd1;
    send(9'h15A);
    drain("div1", 400);

    // Burst of 20 accepted words into d0 at div 2; back-pressure on all.
    div = 16'd2;
    n = 0;
    m_acc[0] = 0;
    valid = 1'b1;
    while ((m_acc[0] < 20) && (n < 2000)) begin
      data = 9'($urandom);
      tick();
      n++;
    end
    valid = 1'b0;
    check("burst accepted 20", m_acc[0], 20);
    drain("burst", 3000);

    // Divisor change mid-frame applies from the next frame only.
    div = 16'd4;
    valid = 1'b1;
    data = 9'h0C3;
    tick();
    data = 9'h13C;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    div = 16'd8;
    drain("divchg", 1000);

    random_phase(3000);
    drain("rand1", 3000);

    // Reset in the middle of a data bit with words still queued.
    div = 16'd4;
    valid = 1'b1;
    repeat (4) begin
      data = 9'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (12) tick();
    n_rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d rst tx", i), tx[i], 1'b1);
      check($sformatf("d%0d rst level", i), dut_level(i), 0);
      check($sformatf("d%0d rst busy", i), busy[i], 1'b0);
      check($sformatf("d%0d rst ready", i), rdy[i], 1'b1);
      model_reset(i);
    end
`ifdef UART_TX_CTS_EN
    c_prev1 = 1'b1;
    c_prev2 = 1'b1;
`endif
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (40) tick();

`ifdef UART_TX_CTS_EN
    // Held by CTS with two words queued, then released.
    cts_n = 1'b1;
    repeat (3) tick();
    valid = 1'b1;
    repeat (2) begin
      data = 9'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (30) tick();
    cts_n = 1'b0;
    repeat (10) tick();
    cts_n = 1'b1;
    repeat (200) tick();
    drain("cts", 2000);
`endif

    random_phase(1500);
    drain("rand2", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
